// File: rtl/calc_entry_fsm.sv
// Key-entry controller for a BCD calculator. It assembles two operands from
// keypad strobes, hands them to an arithmetic unit, and chains or displays results.
module calc_entry_fsm #(
    parameter int NDIG = 6,
    parameter int DW   = 4 * NDIG
) (
    input  logic          CLK_1K,
    input  logic          RST,
    input  logic [3:0]    key_value,
    input  logic          flag,
    input  logic [DW-1:0] num_result,
    input  logic          res_valid,
    input  logic          res_err,
    output logic [DW-1:0] num_reg1,
    output logic [DW-1:0] num_reg2,
    output logic [3:0]    opcode,
    output logic          calc_req,
    output logic [DW-1:0] num_out,
    output logic          err
);

    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [2:0] {
        S_NUM1 = 3'd0,
        S_OP   = 3'd1,
        S_NUM2 = 3'd2,
        S_WAIT = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_num1, w_num1_nxt;
    logic [DW-1:0]   r_num2, w_num2_nxt;
    logic [CW-1:0]   r_cnt1, w_cnt1_nxt;
    logic [CW-1:0]   r_cnt2, w_cnt2_nxt;
    logic [3:0]      r_pend_op, w_pend_op_nxt;
    logic [3:0]      r_next_op, w_next_op_nxt;
    logic [3:0]      r_opcode, w_opcode_nxt;
    logic            r_chain, w_chain_nxt;
    logic            r_calc_req, w_calc_req_nxt;
    logic            r_err, w_err_nxt;

    logic            w_is_digit;
    logic            w_is_op;
    logic            w_is_eq;
    logic            w_is_clr;
    logic            w_dig_ok1;
    logic            w_dig_ok2;
    logic [CW-1:0]   w_first_cnt;
    logic [DW-1:0]   w_first_num;

    // Key classification, qualified by the key strobe
    always_comb begin
        w_is_digit = flag & (key_value <= 4'd9);
        w_is_op    = flag & (key_value >= 4'hA) & (key_value <= 4'hD);
        w_is_eq    = flag & (key_value == 4'hE);
        w_is_clr   = flag & (key_value == 4'hF);
    end

    // Digit acceptance: stop at NDIG digits and suppress leading zeros
    always_comb begin
        w_dig_ok1   = (r_cnt1 != CW'(NDIG)) &&
                      !((r_num1 == {DW{1'b0}}) && (key_value == 4'd0));
        w_dig_ok2   = (r_cnt2 != CW'(NDIG)) &&
                      !((r_num2 == {DW{1'b0}}) && (key_value == 4'd0));
        w_first_cnt = (key_value == 4'd0) ? {CW{1'b0}} : CW'(1);
        w_first_num = {{(DW-4){1'b0}}, key_value};
    end

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt    = r_state;
        w_num1_nxt     = r_num1;
        w_num2_nxt     = r_num2;
        w_cnt1_nxt     = r_cnt1;
        w_cnt2_nxt     = r_cnt2;
        w_pend_op_nxt  = r_pend_op;
        w_next_op_nxt  = r_next_op;
        w_opcode_nxt   = r_opcode;
        w_chain_nxt    = r_chain;
        w_calc_req_nxt = r_calc_req;
        w_err_nxt      = r_err;

        if (w_is_clr) begin
            // Clear wins everywhere, including over a coincident result
            w_state_nxt    = S_NUM1;
            w_num1_nxt     = {DW{1'b0}};
            w_num2_nxt     = {DW{1'b0}};
            w_cnt1_nxt     = {CW{1'b0}};
            w_cnt2_nxt     = {CW{1'b0}};
            w_pend_op_nxt  = 4'd0;
            w_opcode_nxt   = 4'd0;
            w_calc_req_nxt = 1'b0;
            w_err_nxt      = 1'b0;
        end else begin
            case (r_state)
                S_NUM1: begin
                    if (w_is_digit) begin
                        if (w_dig_ok1) begin
                            w_num1_nxt = {r_num1[DW-5:0], key_value};
                            w_cnt1_nxt = r_cnt1 + CW'(1);
                        end else begin
                            w_num1_nxt = r_num1;
                        end
                    end else if (w_is_op) begin
                        w_pend_op_nxt = key_value;
                        w_num2_nxt    = {DW{1'b0}};
                        w_cnt2_nxt    = {CW{1'b0}};
                        w_state_nxt   = S_OP;
                    end else begin
                        w_state_nxt = S_NUM1;
                    end
                end
                S_OP: begin
                    if (w_is_op) begin
                        w_pend_op_nxt = key_value;
                    end else if (w_is_digit) begin
                        w_num2_nxt  = w_first_num;
                        w_cnt2_nxt  = w_first_cnt;
                        w_state_nxt = S_NUM2;
                    end else begin
                        w_state_nxt = S_OP;
                    end
                end
                S_NUM2: begin
                    if (w_is_digit) begin
                        if (w_dig_ok2) begin
                            w_num2_nxt = {r_num2[DW-5:0], key_value};
                            w_cnt2_nxt = r_cnt2 + CW'(1);
                        end else begin
                            w_num2_nxt = r_num2;
                        end
                    end else if (w_is_eq || w_is_op) begin
                        // An operator here both computes and queues the next operation
                        w_opcode_nxt   = r_pend_op;
                        w_calc_req_nxt = 1'b1;
                        w_chain_nxt    = w_is_op;
                        w_next_op_nxt  = w_is_op ? key_value : r_next_op;
                        w_state_nxt    = S_WAIT;
                    end else begin
                        w_state_nxt = S_NUM2;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        w_calc_req_nxt = 1'b0;
                        if (res_err) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_ERR;
                        end else begin
                            w_num1_nxt = num_result;
                            w_num2_nxt = {DW{1'b0}};
                            w_cnt1_nxt = {CW{1'b0}};
                            w_cnt2_nxt = {CW{1'b0}};
                            if (r_chain) begin
                                w_pend_op_nxt = r_next_op;
                                w_state_nxt   = S_OP;
                            end else begin
                                w_state_nxt = S_RES;
                            end
                        end
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_RES: begin
                    if (w_is_digit) begin
                        w_num1_nxt  = w_first_num;
                        w_cnt1_nxt  = w_first_cnt;
                        w_state_nxt = S_NUM1;
                    end else if (w_is_op) begin
                        w_pend_op_nxt = key_value;
                        w_num2_nxt    = {DW{1'b0}};
                        w_cnt2_nxt    = {CW{1'b0}};
                        w_state_nxt   = S_OP;
                    end else begin
                        w_state_nxt = S_RES;
                    end
                end
                S_ERR: begin
                    w_state_nxt = S_ERR;
                end
                default: begin
                    w_state_nxt = S_NUM1;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK_1K) begin
        if (!RST) begin
            r_state <= S_NUM1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand, operator and handshake registers
    always_ff @(posedge CLK_1K) begin
        if (!RST) begin
            r_num1     <= {DW{1'b0}};
            r_num2     <= {DW{1'b0}};
            r_cnt1     <= {CW{1'b0}};
            r_cnt2     <= {CW{1'b0}};
            r_pend_op  <= 4'd0;
            r_next_op  <= 4'd0;
            r_opcode   <= 4'd0;
            r_chain    <= 1'b0;
            r_calc_req <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_num1     <= w_num1_nxt;
            r_num2     <= w_num2_nxt;
            r_cnt1     <= w_cnt1_nxt;
            r_cnt2     <= w_cnt2_nxt;
            r_pend_op  <= w_pend_op_nxt;
            r_next_op  <= w_next_op_nxt;
            r_opcode   <= w_opcode_nxt;
            r_chain    <= w_chain_nxt;
            r_calc_req <= w_calc_req_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Display selection follows the operand being entered
    always_comb begin
        case (r_state)
            S_NUM2, S_WAIT: num_out = r_num2;
            S_ERR:          num_out = {DW{1'b1}};
            default:        num_out = r_num1;
        endcase
    end

    assign num_reg1 = r_num1;
    assign num_reg2 = r_num2;
    assign opcode   = r_opcode;
    assign calc_req = r_calc_req;
    assign err      = r_err;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm: keypad sequences with hand-computed
// register, display and handshake expectations.
module tb_calc_entry_fsm;

    localparam int NDIG = 6;
    localparam int DW   = 24;

    localparam logic [2:0] ST_NUM1 = 3'd0;
    localparam logic [2:0] ST_OP   = 3'd1;
    localparam logic [2:0] ST_NUM2 = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_RES  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    logic          clk_s;
    logic          rst_s;
    logic [3:0]    key_s;
    logic          flag_s;
    logic [DW-1:0] result_s;
    logic          res_valid_s;
    logic          res_err_s;
    logic [DW-1:0] num_reg1_s;
    logic [DW-1:0] num_reg2_s;
    logic [3:0]    opcode_s;
    logic          calc_req_s;
    logic [DW-1:0] num_out_s;
    logic          err_s;

    int total_r;
    int bad_r;

    calc_entry_fsm #(.NDIG(NDIG), .DW(DW)) dut (
        .CLK_1K     (clk_s),
        .RST        (rst_s),
        .key_value  (key_s),
        .flag       (flag_s),
        .num_result (result_s),
        .res_valid  (res_valid_s),
        .res_err    (res_err_s),
        .num_reg1   (num_reg1_s),
        .num_reg2   (num_reg2_s),
        .opcode     (opcode_s),
        .calc_req   (calc_req_s),
        .num_out    (num_out_s),
        .err        (err_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_r = total_r + 1;
        if (got !== exp) begin
            bad_r = bad_r + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus, starting and ending on a falling edge
    task automatic drive_cycle(input logic f, input logic [3:0] k, input logic rv,
                               input logic [DW-1:0] d, input logic re);
        flag_s      = f;
        key_s       = k;
        res_valid_s = rv;
        result_s    = d;
        res_err_s   = re;
        @(negedge clk_s);
        flag_s      = 1'b0;
        key_s       = 4'd0;
        res_valid_s = 1'b0;
        result_s    = {DW{1'b0}};
        res_err_s   = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        drive_cycle(1'b1, k, 1'b0, {DW{1'b0}}, 1'b0);
    endtask

    task automatic result(input logic [DW-1:0] d, input logic re);
        drive_cycle(1'b0, 4'd0, 1'b1, d, re);
    endtask

    initial begin
        total_r     = 0;
        bad_r       = 0;
        rst_s       = 1'b0;
        flag_s      = 1'b0;
        key_s       = 4'd0;
        res_valid_s = 1'b0;
        result_s    = {DW{1'b0}};
        res_err_s   = 1'b0;
        @(negedge clk_s);
        @(negedge clk_s);
        check_val("rst_reg1", 32'(num_reg1_s), 32'h0);
        check_val("rst_reg2", 32'(num_reg2_s), 32'h0);
        check_val("rst_opcode", 32'(opcode_s), 32'h0);
        check_val("rst_calc_req", 32'(calc_req_s), 32'h0);
        check_val("rst_err", 32'(err_s), 32'h0);
        check_val("rst_num_out", 32'(num_out_s), 32'h0);
        rst_s = 1'b1;
        @(negedge clk_s);

        // 12 + 3 = 15
        press(4'd1);
        press(4'd2);
        check_val("op1_entry", 32'(num_reg1_s), 32'h12);
        press(4'hA);
        check_val("state_op", 32'(dut.r_state), 32'(ST_OP));
        check_val("op_num_out", 32'(num_out_s), 32'h12);
        press(4'd3);
        check_val("op2_num_out", 32'(num_out_s), 32'h3);
        press(4'hE);
        check_val("req_calc_req", 32'(calc_req_s), 32'h1);
        check_val("req_opcode", 32'(opcode_s), 32'hA);
        check_val("req_reg1", 32'(num_reg1_s), 32'h12);
        check_val("req_reg2", 32'(num_reg2_s), 32'h3);
        press(4'd5);
        check_val("wait_key_ignored", 32'(num_reg2_s), 32'h3);
        check_val("wait_req_held", 32'(calc_req_s), 32'h1);
        result(24'h000015, 1'b0);
        check_val("res_reg1", 32'(num_reg1_s), 32'h15);
        check_val("res_reg2", 32'(num_reg2_s), 32'h0);
        check_val("res_calc_req", 32'(calc_req_s), 32'h0);
        check_val("state_res", 32'(dut.r_state), 32'(ST_RES));
        check_val("res_num_out", 32'(num_out_s), 32'h15);
        press(4'hE);
        check_val("res_eq_ignored", 32'(dut.r_state), 32'(ST_RES));
        press(4'd7);
        check_val("res_digit_reg1", 32'(num_reg1_s), 32'h7);
        check_val("res_digit_state", 32'(dut.r_state), 32'(ST_NUM1));

        // Digit limit and leading-zero suppression
        press(4'hF);
        for (int i = 1; i <= 7; i++) begin
            press(4'(i));
        end
        check_val("digit_limit", 32'(num_reg1_s), 32'h123456);
        press(4'hF);
        press(4'd0);
        press(4'd0);
        check_val("lead_zero", 32'(num_reg1_s), 32'h0);
        press(4'd5);
        check_val("lead_zero_then5", 32'(num_reg1_s), 32'h5);
        result(24'h000099, 1'b0);
        check_val("res_outside_wait", 32'(num_reg1_s), 32'h5);

        // Chained calculation: 2 A 3 B -> result 5, then C B replaces, 1 E
        press(4'hF);
        press(4'd2);
        press(4'hA);
        press(4'd3);
        press(4'hB);
        check_val("chain_calc_req", 32'(calc_req_s), 32'h1);
        check_val("chain_opcode", 32'(opcode_s), 32'hA);
        result(24'h000005, 1'b0);
        check_val("chain_state", 32'(dut.r_state), 32'(ST_OP));
        check_val("chain_pend", 32'(dut.r_pend_op), 32'hB);
        check_val("chain_reg1", 32'(num_reg1_s), 32'h5);
        press(4'hC);
        press(4'hB);
        check_val("op_replace", 32'(dut.r_pend_op), 32'hB);
        press(4'd1);
        press(4'hE);
        check_val("chain2_calc_req", 32'(calc_req_s), 32'h1);
        check_val("chain2_opcode", 32'(opcode_s), 32'hB);
        result(24'h000006, 1'b0);
        check_val("chain2_num_out", 32'(num_out_s), 32'h6);

        // Error path
        press(4'hF);
        press(4'd9);
        press(4'hD);
        press(4'd0);
        press(4'hE);
        result(24'h000000, 1'b1);
        check_val("err_set", 32'(err_s), 32'h1);
        check_val("err_num_out", 32'(num_out_s), 32'hFFFFFF);
        check_val("err_calc_req", 32'(calc_req_s), 32'h0);
        press(4'd3);
        check_val("err_digit_ignored", 32'(num_out_s), 32'hFFFFFF);
        press(4'hF);
        check_val("err_clear", 32'(err_s), 32'h0);
        check_val("err_clear_out", 32'(num_out_s), 32'h0);

        // Abort in WAIT, then a stale result must be ignored
        press(4'd4);
        press(4'hA);
        press(4'd2);
        press(4'hE);
        press(4'hF);
        check_val("abort_calc_req", 32'(calc_req_s), 32'h0);
        result(24'h000099, 1'b0);
        check_val("abort_state", 32'(dut.r_state), 32'(ST_NUM1));
        check_val("abort_reg1", 32'(num_reg1_s), 32'h0);

        // Coincident clear and result: clear wins
        press(4'd4);
        press(4'hA);
        press(4'd2);
        press(4'hE);
        drive_cycle(1'b1, 4'hF, 1'b1, 24'h000006, 1'b0);
        check_val("coinc_f_reg1", 32'(num_reg1_s), 32'h0);
        check_val("coinc_f_state", 32'(dut.r_state), 32'(ST_NUM1));

        // Coincident digit and result: result wins, key dropped
        press(4'd4);
        press(4'hA);
        press(4'd2);
        press(4'hE);
        drive_cycle(1'b1, 4'd3, 1'b1, 24'h000077, 1'b0);
        check_val("coinc_d_reg1", 32'(num_reg1_s), 32'h77);
        check_val("coinc_d_state", 32'(dut.r_state), 32'(ST_RES));

        // Reset in the middle of a wait overrides strobes
        press(4'd8);
        press(4'hC);
        press(4'd1);
        press(4'hE);
        rst_s = 1'b0;
        drive_cycle(1'b1, 4'd3, 1'b1, 24'h000042, 1'b0);
        rst_s = 1'b1;
        check_val("mid_rst_reg1", 32'(num_reg1_s), 32'h0);
        check_val("mid_rst_reg2", 32'(num_reg2_s), 32'h0);
        check_val("mid_rst_opcode", 32'(opcode_s), 32'h0);
        check_val("mid_rst_calc_req", 32'(calc_req_s), 32'h0);
        check_val("mid_rst_err", 32'(err_s), 32'h0);
        check_val("mid_rst_num_out", 32'(num_out_s), 32'h0);

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule

// File: doc/calc_entry_fsm.md
CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

Interface
REQ-001 The block SHALL have parameter NDIG, default 6, meaning the maximum number of BCD digits per operand.
REQ-002 The block SHALL have parameter DW, default 4*NDIG, meaning the operand and result width in bits.
REQ-003 The block SHALL have port CLK_1K, input, 1, meaning the single system clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, meaning the reset: synchronous, active-low.
REQ-005 The block SHALL have port key_value, input, 4, meaning the key code: 0-9 digit, A-D operator, E equals, F clear.
REQ-006 The block SHALL have port flag, input, 1, meaning a one-cycle key strobe; key_value is valid only when flag=1.
REQ-007 The block SHALL have port num_result, input, DW, meaning the BCD result from the arithmetic unit.
REQ-008 The block SHALL have port res_valid, input, 1, meaning a one-cycle strobe: num_result/res_err are valid.
REQ-009 The block SHALL have port res_err, input, 1, meaning result error (overflow or divide-by-zero), qualified by res_valid.
REQ-010 The block SHALL have port num_reg1, output, DW, meaning operand 1 / accumulator.
REQ-011 The block SHALL have port num_reg2, output, DW, meaning operand 2.
REQ-012 The block SHALL have port opcode, output, 4, meaning the operator presented to the arithmetic unit.
REQ-013 The block SHALL have port calc_req, output, 1, meaning a calculation request, held high until res_valid.
REQ-014 The block SHALL have port num_out, output, DW, meaning the display value.
REQ-015 The block SHALL have port err, output, 1, meaning an error is latched.

Function
REQ-016 The FSM SHALL have states S_NUM1, S_OP, S_NUM2, S_WAIT, S_RES and S_ERR; key actions take effect only on cycles with flag=1.
REQ-017 Digit d in S_NUM1 or S_NUM2 SHALL update the active operand as {op[DW-5:0],d}, with the cycle after the strobe as the visible latency.
REQ-018 Each operand SHALL keep a digit counter (0..NDIG); a digit when the counter is NDIG is ignored (no shift, no wrap).
REQ-019 Digit 0 while the active operand equals 0 SHALL leave the operand and its counter unchanged (no leading zeros).
REQ-020 Operator A-D in S_NUM1 or S_RES SHALL latch pending_op, clear num_reg2 and its counter, and go to S_OP.
REQ-021 Operator in S_OP SHALL replace pending_op only (last operator wins).
REQ-022 Digit in S_OP SHALL load num_reg2=d (counter 1, or 0 if d=0) and go to S_NUM2.
REQ-023 E in S_NUM2 SHALL drive opcode=pending_op, assert calc_req, set chain=0, and go to S_WAIT.
REQ-024 Operator X in S_NUM2 SHALL do the same with chain=1 and next_op=X (chained calculation).
REQ-025 E in S_NUM1, S_OP or S_RES SHALL be ignored.
REQ-026 Digit in S_RES SHALL clear num_reg1, load d, set its counter and go to S_NUM1.
REQ-027 In S_WAIT, all keys except F SHALL be ignored; calc_req, opcode, num_reg1 and num_reg2 are stable.
REQ-028 res_valid with res_err=0 in S_WAIT SHALL set num_reg1=num_result, clear num_reg2 and both counters, and deassert calc_req the next cycle.
REQ-029 After REQ-028 the next state SHALL be S_RES when chain=0, or S_OP with pending_op=next_op when chain=1.
REQ-030 res_valid with res_err=1 in S_WAIT SHALL deassert calc_req, set err=1 and go to S_ERR.
REQ-031 res_valid outside S_WAIT SHALL be ignored.
REQ-032 In S_ERR only F SHALL have effect; all other keys are ignored.
REQ-033 F in any state SHALL clear num_reg1, num_reg2, counters, pending_op, opcode, calc_req and err, and go to S_NUM1; in S_WAIT it aborts, and a later res_valid is ignored.
REQ-034 If flag and res_valid coincide in S_WAIT, F SHALL take priority; otherwise the result is accepted and the key dropped.
REQ-035 num_out SHALL be num_reg2 in S_NUM2 and S_WAIT, all-ones in S_ERR, and num_reg1 otherwise (combinational).

Reset
REQ-036 RST=0 at a rising CLK_1K edge SHALL force S_NUM1, num_reg1=0, num_reg2=0, opcode=0, pending_op=0, chain=0, counters=0, calc_req=0 and err=0, overriding flag and res_valid, including mid-S_WAIT.

Verification
REQ-037 Keys 1,2,A,3,E; then res_valid with num_result=0x000015 -> calc_req high with opcode=A, num_reg1=0x12, num_reg2=0x3; then num_reg1=0x15, state S_RES, num_out=0x15.
REQ-038 Seven digits 1..7 with NDIG=6 -> num_reg1=0x123456; leading 0,0,5 -> num_reg1=0x5.
REQ-039 Keys 2,A,3,B -> calc_req with opcode=A; after res_valid with 0x5 -> S_OP, pending_op=B, num_reg1=0x5; then 1,E -> calc_req with opcode=B.
REQ-040 res_valid with res_err=1 -> err=1 and num_out all-ones; digit keys ignored; F -> err=0 and num_out=0.
REQ-041 F during S_WAIT followed by res_valid -> S_NUM1 and num_reg1 stays 0; RST=0 asserted mid-S_WAIT -> all outputs 0 on the next edge.
